// File: rtl/seg_pkg.sv
// Shared types and glyph constants for the segment scan controller.
// Glyphs are active-low, bit order g..a.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    BLANK  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_A   = 7'h08;
  localparam logic [6:0] SEG_B   = 7'h03;
  localparam logic [6:0] SEG_C   = 7'h46;
  localparam logic [6:0] SEG_D   = 7'h21;
  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_F   = 7'h0E;
  localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/segment_scan_controller_if.sv
// Display-side bundle of the segment scan controller.
// master drives digits/enable, slave is the scanner.
interface segment_scan_controller_if #(
  parameter int NUM_DIGITS = 3,
  parameter int IDX_W      = 3
);

  logic                    i_enable;
  logic [4*NUM_DIGITS-1:0] i_digits;
  logic [NUM_DIGITS-1:0]   i_dp;
  logic [NUM_DIGITS-1:0]   o_segmentEnable;
  logic [6:0]              o_segments;
  logic                    o_dp;
  logic [IDX_W-1:0]        o_digit_idx;
  logic                    o_frame_tick;

  modport master (
    output i_enable,
    output i_digits,
    output i_dp,
    input  o_segmentEnable,
    input  o_segments,
    input  o_dp,
    input  o_digit_idx,
    input  o_frame_tick
  );

  modport slave (
    input  i_enable,
    input  i_digits,
    input  i_dp,
    output o_segmentEnable,
    output o_segments,
    output o_dp,
    output o_digit_idx,
    output o_frame_tick
  );

endinterface

// File: rtl/seg7_hex_decoder.sv
// Nibble to active-low 7-segment hex glyph.
// Pure combinational lookup.
module seg7_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  always_comb begin
    segments = SEG_OFF;
    unique case (nibble)
      4'h0: segments = SEG_0;
      4'h1: segments = SEG_1;
      4'h2: segments = SEG_2;
      4'h3: segments = SEG_3;
      4'h4: segments = SEG_4;
      4'h5: segments = SEG_5;
      4'h6: segments = SEG_6;
      4'h7: segments = SEG_7;
      4'h8: segments = SEG_8;
      4'h9: segments = SEG_9;
      4'hA: segments = SEG_A;
      4'hB: segments = SEG_B;
      4'hC: segments = SEG_C;
      4'hD: segments = SEG_D;
      4'hE: segments = SEG_E;
      4'hF: segments = SEG_F;
    endcase
  end

endmodule

// File: rtl/segment_scan_controller.sv
// Multiplexed 7-segment scanner with blanking gap and per-frame snapshot.
// Optional LEADING_ZERO_BLANK_EN darkens leading zero digits.
module segment_scan_controller
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 3,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2,
  parameter int IDX_W        = 3
) (
  input logic i_clk,
  input logic i_rst,
  segment_scan_controller_if.slave bus
);

  localparam int CNT_MAX =
    (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] ACT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLK_LAST =
    CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [IDX_W-1:0]        idx, idx_n;
  logic [4*NUM_DIGITS-1:0] snap_d, snap_d_n;
  logic [NUM_DIGITS-1:0]   snap_dp, snap_dp_n;
  logic                    tick_n;
  logic                    advance;

  logic [3:0]            nib;
  logic                  dp_sel;
  logic [NUM_DIGITS-1:0] en_n;
  logic [6:0]            glyph;
  logic                  lz;
  logic                  lit;

  // Next-state: counters, digit index and the frame snapshot
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    snap_d_n  = snap_d;
    snap_dp_n = snap_dp;
    tick_n    = 1'b0;
    advance   = 1'b0;
    if (!bus.i_enable) begin
      state_n = IDLE;
      cnt_n   = '0;
      idx_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n   = ACTIVE;
          cnt_n     = '0;
          idx_n     = '0;
          snap_d_n  = bus.i_digits;
          snap_dp_n = bus.i_dp;
        end
        ACTIVE: begin
          if (cnt == ACT_LAST) begin
            cnt_n = '0;
            if (BLANK_CYCLES > 0) state_n = BLANK;
            else                  advance = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        BLANK: begin
          if (cnt == BLK_LAST) begin
            cnt_n   = '0;
            state_n = ACTIVE;
            advance = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          idx_n   = '0;
        end
      endcase
      if (advance) begin
        if (idx == IDX_LAST) begin
          idx_n     = '0;
          tick_n    = 1'b1;
          snap_d_n  = bus.i_digits;
          snap_dp_n = bus.i_dp;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
    end
  end

  // Digit select works on next-cycle values so outputs stay registered
  always_comb begin
    nib    = 4'h0;
    dp_sel = 1'b0;
    en_n   = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_n == IDX_W'(k)) begin
        nib     = snap_d_n[4*k +: 4];
        dp_sel  = snap_dp_n[k];
        en_n[k] = 1'b0;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic zrun;

  always_comb begin
    zrun = 1'b1;
    lz   = 1'b0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zrun = zrun & (snap_d_n[4*k +: 4] == 4'h0);
      if (idx_n == IDX_W'(k) && zrun) lz = 1'b1;
    end
  end
`else
  assign lz = 1'b0;
`endif

  seg7_hex_decoder u_dec (
    .nibble   (nib),
    .segments (glyph)
  );

  assign lit = (state_n == ACTIVE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state               <= IDLE;
      cnt                 <= '0;
      idx                 <= '0;
      snap_d              <= '0;
      snap_dp             <= '0;
      bus.o_segmentEnable <= '1;
      bus.o_segments      <= SEG_OFF;
      bus.o_dp            <= 1'b1;
      bus.o_digit_idx     <= '0;
      bus.o_frame_tick    <= 1'b0;
    end else begin
      state               <= state_n;
      cnt                 <= cnt_n;
      idx                 <= idx_n;
      snap_d              <= snap_d_n;
      snap_dp             <= snap_dp_n;
      bus.o_segmentEnable <= lit ? en_n : '1;
      bus.o_segments      <= (lit && !lz) ? glyph : SEG_OFF;
      bus.o_dp            <= lit ? ~dp_sel : 1'b1;
      bus.o_digit_idx     <= idx_n;
      bus.o_frame_tick    <= tick_n;
    end
  end

endmodule

// File: tb/tb_segment_scan_controller.sv
// Bench for segment_scan_controller: 4 digits, REFRESH_DIV 4,
// one DUT with BLANK_CYCLES 1 and one with BLANK_CYCLES 0.
module tb_segment_scan_controller;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [27:0] segs;
  } vec_t;

  typedef struct {
    logic [3:0] en;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] idx;
    logic       tick;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en1 = 1'b0;
  logic        en0 = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dpv = '0;
  logic        sel = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t q[$];
  vec_t tbl[7];

  always #5 clk = ~clk;

  segment_scan_controller_if #(.NUM_DIGITS(4), .IDX_W(3)) b1 ();
  segment_scan_controller_if #(.NUM_DIGITS(4), .IDX_W(3)) b0 ();

  assign b1.i_enable = en1;
  assign b1.i_digits = digits;
  assign b1.i_dp     = dpv;
  assign b0.i_enable = en0;
  assign b0.i_digits = digits;
  assign b0.i_dp     = dpv;

  segment_scan_controller #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .IDX_W(3)
  ) dut1 (
    .i_clk(clk), .i_rst(rst), .bus(b1.slave)
  );

  segment_scan_controller #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(0), .IDX_W(3)
  ) dut0 (
    .i_clk(clk), .i_rst(rst), .bus(b0.slave)
  );

  logic [3:0] o_en;
  logic [6:0] o_seg;
  logic       o_dp;
  logic [2:0] o_idx;
  logic       o_tick;

  always_comb begin
    o_en   = sel ? b1.o_segmentEnable : b0.o_segmentEnable;
    o_seg  = sel ? b1.o_segments      : b0.o_segments;
    o_dp   = sel ? b1.o_dp            : b0.o_dp;
    o_idx  = sel ? b1.o_digit_idx     : b0.o_digit_idx;
    o_tick = sel ? b1.o_frame_tick    : b0.o_frame_tick;
  end

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  // At most one digit enable low, every cycle, both DUTs
  always @(negedge clk) begin
    n_cmp++;
    if (!$onehot0(~b1.o_segmentEnable) || !$onehot0(~b0.o_segmentEnable)) begin
      n_bad++;
      $display("FAIL onecold: b1 %b b0 %b, want at most one 0",
               b1.o_segmentEnable, b0.o_segmentEnable);
    end
  end

  task automatic chk_dark(input string tag);
    chk({tag, " en"},   8'(o_en),   8'h0F);
    chk({tag, " seg"},  8'(o_seg),  8'h7F);
    chk({tag, " dp"},   8'(o_dp),   8'h01);
    chk({tag, " idx"},  8'(o_idx),  8'h00);
    chk({tag, " tick"}, 8'(o_tick), 8'h00);
  endtask

  task automatic play(input int blank, input logic [3:0] dpm,
                      input logic [27:0] segs, input bit tick_first,
                      input int ncyc, input int change_at,
                      input logic [15:0] nd, input logic [3:0] ndp);
    int   per;
    int   slot;
    int   pos;
    exp_t e;
    per = 4 + blank;
    for (int c = 0; c < ncyc; c++) begin
      slot  = c / per;
      pos   = c % per;
      e.idx = 3'(slot);
      e.tick = (c == 0) && tick_first;
      if (pos < 4) begin
        e.en  = ~(4'b0001 << slot);
        e.seg = segs[7*slot +: 7];
        e.dp  = ~dpm[slot];
      end else begin
        e.en  = 4'hF;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
      end
      q.push_back(e);
    end
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      e = q.pop_front();
      chk($sformatf("en c%0d", c),   8'(o_en),   8'(e.en));
      chk($sformatf("seg c%0d", c),  8'(o_seg),  8'(e.seg));
      chk($sformatf("dp c%0d", c),   8'(o_dp),   8'(e.dp));
      chk($sformatf("idx c%0d", c),  8'(o_idx),  8'(e.idx));
      chk($sformatf("tick c%0d", c), 8'(o_tick), 8'(e.tick));
      if (c == change_at) begin
        digits = nd;
        dpv    = ndp;
      end
    end
  endtask

  initial begin
    tbl[0] = '{16'h1234, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}};
    tbl[1] = '{16'hABCD, 4'b0101, {7'h08, 7'h03, 7'h46, 7'h21}};
    tbl[2] = '{16'h5678, 4'b1000, {7'h12, 7'h02, 7'h78, 7'h00}};
    tbl[3] = '{16'h90EF, 4'b0011, {7'h10, 7'h40, 7'h06, 7'h0E}};
`ifdef LEADING_ZERO_BLANK_EN
    tbl[4] = '{16'h0050, 4'b0000, {7'h7F, 7'h7F, 7'h12, 7'h40}};
    tbl[5] = '{16'h0000, 4'b0100, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    tbl[6] = '{16'h0F00, 4'b1000, {7'h7F, 7'h0E, 7'h40, 7'h40}};
`else
    tbl[4] = '{16'h0050, 4'b0000, {7'h40, 7'h40, 7'h12, 7'h40}};
    tbl[5] = '{16'h0000, 4'b0100, {7'h40, 7'h40, 7'h40, 7'h40}};
    tbl[6] = '{16'h0F00, 4'b1000, {7'h40, 7'h0E, 7'h40, 7'h40}};
`endif

    repeat (2) @(negedge clk);
    chk_dark("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_dark("idle");

    // Back-to-back frames; next entry is driven mid-frame
    digits = tbl[0].digits;
    dpv    = tbl[0].dp;
    en1    = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i < 6)
        play(1, tbl[i].dp, tbl[i].segs, i > 0, 20, 7,
             tbl[i+1].digits, tbl[i+1].dp);
      else
        play(1, tbl[i].dp, tbl[i].segs, 1'b1, 20, -1, 16'h0, 4'h0);
    end

    // Disable at frame boundary, then mid digit 2
    en1 = 1'b0;
    @(negedge clk);
    chk_dark("dis_wrap");
    digits = 16'h1234;
    dpv    = 4'b0000;
    en1    = 1'b1;
    play(1, 4'b0000, tbl[0].segs, 1'b0, 12, -1, 16'h0, 4'h0);
    en1 = 1'b0;
    @(negedge clk);
    chk_dark("dis_mid");
    en1 = 1'b1;
    play(1, 4'b0000, tbl[0].segs, 1'b0, 20, -1, 16'h0, 4'h0);

    // Async reset while lit
    @(negedge clk);
    chk("pre_rst en", 8'(o_en), 8'h0E);
    #2 rst = 1'b1;
    #1 chk_dark("async_rst");
    en1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // No blanking gap
    sel    = 1'b0;
    digits = 16'h1234;
    dpv    = 4'b0010;
    en0    = 1'b1;
    play(0, 4'b0010, tbl[0].segs, 1'b0, 16, 3, 16'h5678, 4'b1000);
    play(0, 4'b1000, tbl[2].segs, 1'b1, 16, -1, 16'h0, 4'h0);
    en0 = 1'b0;
    @(negedge clk);
    chk_dark("dis_b0");

    chk("queue empty", 8'(q.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
